// File: rtl/sync_fifo_bypass_pkg.sv
// Shared helpers for the elastic-buffer FIFO family: width calculations and
// pointer increment with explicit wrap so any depth (not just powers of two) works.
package fifo_pkg;

  typedef int unsigned width_t;

  // Bits needed to hold an occupancy from 0 up to and including depth.
  function automatic width_t cnt_width(input width_t depth);
    return $clog2(depth + 1);
  endfunction

  function automatic width_t ptr_width(input width_t depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic width_t ptr_inc(input width_t ptr, input width_t depth);
    return (ptr >= depth - 1) ? '0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_bypass_if.sv
// Write/read valid-ready channels of the bypass FIFO; master is the producer/consumer
// side of the pipeline, slave is the FIFO itself.
interface sync_fifo_bypass_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid,
    output wr_data,
    output rd_ready,
    input  wr_ready,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  rd_ready,
    output wr_ready,
    output rd_valid,
    output rd_data
  );

endinterface

// File: rtl/sync_fifo_bypass_ptr_ctrl.sv
// Pointer, occupancy and flag bookkeeping for the bypass FIFO. Callers only raise
// push when not full and pop when not empty; flush and reset both return to empty.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH          = 16,
  parameter int ALMOST_FULL_THRESH  = 12,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               push,
  input  logic                               pop,
  output logic [ptr_width(FIFO_DEPTH)-1:0]   wr_ptr,
  output logic [ptr_width(FIFO_DEPTH)-1:0]   rd_ptr,
  output logic [cnt_width(FIFO_DEPTH)-1:0]   count,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               almost_empty
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int CW = cnt_width(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= PW'(ptr_inc(width_t'(wr_ptr), width_t'(FIFO_DEPTH)));
      end
      if (pop) begin
        rd_ptr <= PW'(ptr_inc(width_t'(rd_ptr), width_t'(FIFO_DEPTH)));
      end
      // A simultaneous push and pop leaves occupancy untouched.
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Flags derive only from the registered count, so they cannot glitch on handshakes.
  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(ALMOST_FULL_THRESH));
  assign almost_empty = (count <= CW'(ALMOST_EMPTY_THRESH));

endmodule

// File: rtl/sync_fifo_bypass.sv
// Single-clock first-word-fall-through FIFO with optional empty-state bypass,
// occupancy count, almost-full/empty flags and synchronous flush.
module sync_fifo_bypass
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int FIFO_DEPTH          = 16,
  parameter bit ENABLE_BYPASS       = 1'b0,
  parameter int ALMOST_FULL_THRESH  = 12,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  sync_fifo_bypass_if.slave                bus,
  output logic [cnt_width(FIFO_DEPTH)-1:0] count,
  output logic                             almost_full,
  output logic                             almost_empty
);

  localparam int PW = ptr_width(FIFO_DEPTH);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_bypass: DATA_WIDTH must be at least 1");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_bypass: FIFO_DEPTH must be at least 2");
  end
  if (!(ALMOST_EMPTY_THRESH < ALMOST_FULL_THRESH && ALMOST_FULL_THRESH <= FIFO_DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_bypass: need ALMOST_EMPTY_THRESH < ALMOST_FULL_THRESH <= FIFO_DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  bypass_mode;
  logic                  bypass_xfer;
  logic                  push;
  logic                  pop;

  // With bypass enabled an empty FIFO presents the incoming word directly; if the
  // consumer takes it that cycle it never touches storage.
  assign bypass_mode = ENABLE_BYPASS && empty;
  assign bypass_xfer = bypass_mode && bus.wr_valid && bus.rd_ready;

  assign bus.wr_ready = !full;
  assign bus.rd_valid = bypass_mode ? bus.wr_valid : !empty;
  assign bus.rd_data  = bypass_mode ? bus.wr_data  : mem[rd_ptr];

  assign push = bus.wr_valid && !full && !bypass_xfer;
  assign pop  = bus.rd_ready && !empty;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  fifo_ptr_ctrl #(
    .FIFO_DEPTH          (FIFO_DEPTH),
    .ALMOST_FULL_THRESH  (ALMOST_FULL_THRESH),
    .ALMOST_EMPTY_THRESH (ALMOST_EMPTY_THRESH)
  ) u_ptr_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .push         (push),
    .pop          (pop),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

endmodule

// File: tb/tb_sync_fifo_bypass.sv
// Self-checking bench: three FIFO configurations (16 deep, 5 deep, 4 deep with bypass)
// driven by directed scenarios and random traffic against a queue-based model.
module tb_sync_fifo_bypass;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sync_fifo_bypass_if #(.DATA_WIDTH(32)) bus_a ();
  sync_fifo_bypass_if #(.DATA_WIDTH(32)) bus_b ();
  sync_fifo_bypass_if #(.DATA_WIDTH(32)) bus_c ();

  logic       flush_a, flush_b, flush_c;
  logic [4:0] count_a;
  logic [2:0] count_b, count_c;
  logic       af_a, ae_a, af_b, ae_b, af_c, ae_c;

  sync_fifo_bypass #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .ENABLE_BYPASS(1'b0),
                     .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a),
    .count(count_a), .almost_full(af_a), .almost_empty(ae_a));

  sync_fifo_bypass #(.DATA_WIDTH(32), .FIFO_DEPTH(5), .ENABLE_BYPASS(1'b0),
                     .ALMOST_FULL_THRESH(4), .ALMOST_EMPTY_THRESH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b),
    .count(count_b), .almost_full(af_b), .almost_empty(ae_b));

  sync_fifo_bypass #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .ENABLE_BYPASS(1'b1),
                     .ALMOST_FULL_THRESH(3), .ALMOST_EMPTY_THRESH(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .bus(bus_c),
    .count(count_c), .almost_full(af_c), .almost_empty(ae_c));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    bus_a.wr_valid = 1'b0; bus_a.rd_ready = 1'b0; bus_a.wr_data = '0; flush_a = 1'b0;
    bus_b.wr_valid = 1'b0; bus_b.rd_ready = 1'b0; bus_b.wr_data = '0; flush_b = 1'b0;
    bus_c.wr_valid = 1'b0; bus_c.rd_ready = 1'b0; bus_c.wr_data = '0; flush_c = 1'b0;
  endtask

  task automatic do_reset;
    idle_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [63:0] got, exp;
    do_reset();
    bus_a.wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_a.wr_data = 32'(i + 1);
      step();
    end
    bus_a.rd_ready = 1'b1;
    @(negedge clk);
    got = 64'(count_a); exp = 64'd5;
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL reset_prefill_count: got %0h expected %0h", got, exp); end
    #2;
    rst_n = 1'b0;
    #1;
    got = 64'({count_a, bus_a.rd_valid, bus_a.wr_ready, ae_a, af_a});
    exp = 64'({5'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL reset_async cnt/rv/wr/ae/af: got %0h expected %0h", got, exp); end
    idle_all();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    got = 64'({count_a, bus_a.rd_valid, ae_a});
    exp = 64'({5'd0, 1'b0, 1'b1});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL reset_release cnt/rv/ae: got %0h expected %0h", got, exp); end
    step();
  endtask

  task automatic test_fill;
    logic [63:0] got, exp;
    bus_a.wr_valid = 1'b1;
    bus_a.rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_a.wr_data = 32'(i);
      @(negedge clk);
      got = 64'({count_a, bus_a.wr_ready, bus_a.rd_valid, af_a, ae_a});
      exp = 64'({5'(i), 1'b1, 1'(i != 0), 1'(i >= 12), 1'(i <= 2)});
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL fill_%0d cnt/wr/rv/af/ae: got %0h expected %0h", i, got, exp); end
      step();
    end
    bus_a.wr_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = 64'({count_a, bus_a.wr_ready, af_a, ae_a});
      exp = 64'({5'd16, 1'b0, 1'b1, 1'b0});
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL fill_full_%0d cnt/wr/af/ae: got %0h expected %0h", i, got, exp); end
      step();
    end
    bus_a.wr_valid = 1'b0;
  endtask

  task automatic test_drain;
    logic [63:0] got, exp;
    int left;
    bus_a.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      left = 16 - i;
      @(negedge clk);
      got = 64'({count_a, bus_a.rd_valid, bus_a.wr_ready, af_a, ae_a, bus_a.rd_data});
      exp = 64'({5'(left), 1'b1, 1'(left != 16), 1'(left >= 12), 1'(left <= 2), 32'(i)});
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL drain_%0d cnt/rv/wr/af/ae/data: got %0h expected %0h", i, got, exp); end
      step();
    end
    @(negedge clk);
    got = 64'({count_a, bus_a.rd_valid, ae_a});
    exp = 64'({5'd0, 1'b0, 1'b1});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL drain_empty cnt/rv/ae: got %0h expected %0h", got, exp); end
    step();
    bus_a.rd_ready = 1'b0;
  endtask

  task automatic test_wrap;
    logic [63:0] got, exp;
    do_reset();
    bus_b.wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus_b.wr_data = 32'h100 + 32'(k);
      step();
    end
    bus_b.rd_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus_b.wr_data = 32'h103 + 32'(c);
      @(negedge clk);
      got = 64'({count_b, bus_b.rd_valid, af_b, ae_b, bus_b.rd_data});
      exp = 64'({3'd3, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(c)});
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL wrap_%0d cnt/rv/af/ae/data: got %0h expected %0h", c, got, exp); end
      step();
    end
    idle_all();
    @(negedge clk);
    got = 64'({count_b, bus_b.rd_data});
    exp = 64'({3'd3, 32'h114});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL wrap_final cnt/data: got %0h expected %0h", got, exp); end
    step();
  endtask

  task automatic test_bypass;
    logic [63:0] got, exp;
    do_reset();
    bus_c.wr_valid = 1'b1; bus_c.wr_data = 32'hA5; bus_c.rd_ready = 1'b1;
    @(negedge clk);
    got = 64'({count_c, bus_c.rd_valid, bus_c.wr_ready, bus_c.rd_data});
    exp = 64'({3'd0, 1'b1, 1'b1, 32'hA5});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL bypass_same_cycle cnt/rv/wr/data: got %0h expected %0h", got, exp); end
    step();
    idle_all();
    @(negedge clk);
    got = 64'({count_c, bus_c.rd_valid});
    exp = 64'({3'd0, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL bypass_consumed cnt/rv: got %0h expected %0h", got, exp); end
    bus_c.wr_valid = 1'b1; bus_c.wr_data = 32'hA5; bus_c.rd_ready = 1'b0;
    step();
    bus_c.wr_data = 32'h3C; bus_c.rd_ready = 1'b1;
    @(negedge clk);
    got = 64'({count_c, bus_c.rd_valid, bus_c.rd_data});
    exp = 64'({3'd1, 1'b1, 32'hA5});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL bypass_stalled_store cnt/rv/data: got %0h expected %0h", got, exp); end
    step();
    idle_all();
    @(negedge clk);
    got = 64'({count_c, bus_c.rd_valid, bus_c.rd_data});
    exp = 64'({3'd1, 1'b1, 32'h3C});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL bypass_nonempty_order cnt/rv/data: got %0h expected %0h", got, exp); end
    bus_c.rd_ready = 1'b1;
    step();
    idle_all();
  endtask

  task automatic test_flush;
    logic [63:0] got, exp;
    do_reset();
    bus_a.wr_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus_a.wr_data = 32'h200 + 32'(k);
      step();
    end
    bus_a.wr_data = 32'hBAD; bus_a.rd_ready = 1'b1; flush_a = 1'b1;
    step();
    idle_all();
    @(negedge clk);
    got = 64'({count_a, bus_a.rd_valid, bus_a.wr_ready, ae_a, af_a});
    exp = 64'({5'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL flush_clear cnt/rv/wr/ae/af: got %0h expected %0h", got, exp); end
    bus_a.wr_valid = 1'b1; bus_a.wr_data = 32'h77;
    step();
    idle_all();
    @(negedge clk);
    got = 64'({count_a, bus_a.rd_valid, bus_a.rd_data});
    exp = 64'({5'd1, 1'b1, 32'h77});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL flush_after_push cnt/rv/data: got %0h expected %0h", got, exp); end
    bus_c.wr_valid = 1'b1; bus_c.wr_data = 32'h99; bus_c.rd_ready = 1'b0; flush_c = 1'b1;
    step();
    idle_all();
    @(negedge clk);
    got = 64'({count_c, bus_c.rd_valid});
    exp = 64'({3'd0, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL flush_bypass_push cnt/rv: got %0h expected %0h", got, exp); end
    step();
  endtask

  task automatic test_random_plain;
    logic [31:0] q[$];
    logic [63:0] got, exp;
    logic        wv, rr, fl, do_push, do_pop;
    int          bias;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bias = ((cyc / 100) % 2 == 0) ? 75 : 30;
      wv = ($urandom_range(0, 99) < bias);
      rr = ($urandom_range(0, 99) < (100 - bias));
      fl = ($urandom_range(0, 99) < 2);
      bus_a.wr_valid = wv; bus_a.rd_ready = rr; bus_a.wr_data = $urandom; flush_a = fl;
      @(negedge clk);
      got = 64'({count_a, bus_a.wr_ready, bus_a.rd_valid, af_a, ae_a});
      exp = 64'({5'(q.size()), 1'(q.size() != 16), 1'(q.size() != 0), 1'(q.size() >= 12), 1'(q.size() <= 2)});
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL rand_plain_%0d cnt/wr/rv/af/ae: got %0h expected %0h", cyc, got, exp); end
      if (q.size() != 0) begin
        checks++;
        if (bus_a.rd_data !== q[0]) begin errors++; $display("[TB] FAIL rand_plain_data_%0d: got %0h expected %0h", cyc, bus_a.rd_data, q[0]); end
      end
      if (fl) begin
        q.delete();
      end else begin
        do_push = wv && (q.size() < 16);
        do_pop  = rr && (q.size() > 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(bus_a.wr_data);
      end
      step();
    end
    idle_all();
  endtask

  task automatic test_random_bypass;
    logic [31:0] q[$];
    logic [63:0] got, exp;
    logic        wv, rr, fl, do_push, do_pop;
    logic [31:0] wd, exp_data;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      wv = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 3);
      wd = $urandom;
      bus_c.wr_valid = wv; bus_c.rd_ready = rr; bus_c.wr_data = wd; flush_c = fl;
      @(negedge clk);
      got = 64'({count_c, bus_c.wr_ready, bus_c.rd_valid, af_c, ae_c});
      exp = 64'({3'(q.size()), 1'(q.size() != 4), 1'(q.size() != 0 || wv), 1'(q.size() >= 3), 1'(q.size() <= 1)});
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL rand_bypass_%0d cnt/wr/rv/af/ae: got %0h expected %0h", cyc, got, exp); end
      if (q.size() != 0 || wv) begin
        exp_data = (q.size() != 0) ? q[0] : wd;
        checks++;
        if (bus_c.rd_data !== exp_data) begin errors++; $display("[TB] FAIL rand_bypass_data_%0d: got %0h expected %0h", cyc, bus_c.rd_data, exp_data); end
      end
      if (fl) begin
        q.delete();
      end else if (!(q.size() == 0 && wv && rr)) begin
        do_push = wv && (q.size() < 4);
        do_pop  = rr && (q.size() > 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(wd);
      end
      step();
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    $display("[TB] starting sync_fifo_bypass bench");
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_bypass();
    test_flush();
    test_random_plain();
    test_random_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
